// File: rtl/uart_byte_rx.sv
`timescale 1ns/1ps
// uart_byte_rx: 8N1 serial-to-parallel receiver, LSB first, 16x oversampled with 3-sample majority vote.
// Latency: rx_done/frame_err 3 clk + 153 oversample ticks after the line's falling edge (mid stop bit).
// Backpressure: none; rx_done/frame_err are one-cycle strobes, data_byte holds until the next good frame.
module uart_byte_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int OSR      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_set,
    input  logic       uart_rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       uart_state
);

    // Clock cycles per oversample tick for each supported baud rate.
    localparam int DIV0  = CLK_FREQ / (9600   * OSR);
    localparam int DIV1  = CLK_FREQ / (19200  * OSR);
    localparam int DIV2  = CLK_FREQ / (38400  * OSR);
    localparam int DIV3  = CLK_FREQ / (57600  * OSR);
    localparam int DIV4  = CLK_FREQ / (115200 * OSR);
    // The slowest rate has the largest divider and sets the counter width.
    localparam int CNT_W = (DIV0 > 1) ? $clog2(DIV0) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_rx_d;
    logic [CNT_W-1:0]   r_div_m1;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic [3:0]         r_samp_cnt;
    logic [2:0]         r_bit_cnt;
    logic               r_s7;
    logic               r_s8;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_rx_done;
    logic               r_frame_err;
    logic               r_uart_state;

    logic [CNT_W-1:0]   w_div_m1;
    logic               w_fall;
    logic               w_tick;
    logic               w_maj;
    logic               w_mid;
    logic               w_bit_end;

    // Select the tick divider for the requested rate; unused codes fall back to 9600.
    always_comb begin
        w_div_m1 = CNT_W'(DIV0 - 1);
        case (baud_set)
            3'd1:    w_div_m1 = CNT_W'(DIV1 - 1);
            3'd2:    w_div_m1 = CNT_W'(DIV2 - 1);
            3'd3:    w_div_m1 = CNT_W'(DIV3 - 1);
            3'd4:    w_div_m1 = CNT_W'(DIV4 - 1);
            default: w_div_m1 = CNT_W'(DIV0 - 1);
        endcase
    end

    // Two-flop synchroniser for the asynchronous line plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_rx_d  <= r_sync2;
        end
    end

    assign w_fall    = r_rx_d & ~r_sync2;
    assign w_tick    = (r_tick_cnt == r_div_m1);
    // Samples land at ticks 7, 8 and 9 of a bit; tick 9 is the current synchronised value.
    assign w_maj     = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
    assign w_mid     = w_tick && (r_samp_cnt == 4'd8);
    assign w_bit_end = w_tick && (r_samp_cnt == 4'd15);

    // Receive FSM with its tick/sample/bit counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_div_m1     <= '0;
            r_tick_cnt   <= '0;
            r_samp_cnt   <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_s7         <= 1'b1;
            r_s8         <= 1'b1;
            r_shift      <= 8'h00;
            r_data       <= 8'h00;
            r_rx_done    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_uart_state <= 1'b0;
        end else begin
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;

            // Counters idle at zero so each frame starts its timing from the detected edge.
            if (r_state == S_IDLE) begin
                r_tick_cnt <= '0;
                r_samp_cnt <= 4'd0;
                r_bit_cnt  <= 3'd0;
            end else if (w_tick) begin
                r_tick_cnt <= '0;
                r_samp_cnt <= r_samp_cnt + 4'd1;
            end else begin
                r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end

            if (w_tick && (r_samp_cnt == 4'd6)) begin
                r_s7 <= r_sync2;
            end
            if (w_tick && (r_samp_cnt == 4'd7)) begin
                r_s8 <= r_sync2;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state      <= S_START;
                        r_uart_state <= 1'b1;
                        // Rate is frozen for the whole frame.
                        r_div_m1     <= w_div_m1;
                    end
                end
                S_START: begin
                    if (w_mid && w_maj) begin
                        // Start bit was high at its centre: a glitch, drop it silently.
                        r_state      <= S_IDLE;
                        r_uart_state <= 1'b0;
                    end else if (w_bit_end) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_mid) begin
                        r_shift <= {w_maj, r_shift[7:1]};
                    end
                    if (w_bit_end) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    // Decide at mid-stop so a following start edge is never missed.
                    if (w_mid) begin
                        if (w_maj) begin
                            r_data       <= r_shift;
                            r_rx_done    <= 1'b1;
                            r_state      <= S_IDLE;
                            r_uart_state <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Hold off start detection until the line recovers to idle.
                    if (r_sync2) begin
                        r_state      <= S_IDLE;
                        r_uart_state <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_uart_state <= 1'b0;
                end
            endcase
        end
    end

    assign data_byte  = r_data;
    assign rx_done    = r_rx_done;
    assign frame_err  = r_frame_err;
    assign uart_state = r_uart_state;

endmodule

// File: tb/tb_uart_byte_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_byte_rx: frame-level reference model feeds a scoreboard queue,
// an independent monitor checks every rx_done/frame_err strobe for kind, data and arrival cycle.
// A reduced clock frequency keeps every baud rate affordable in simulation time.
module tb_uart_byte_rx;

    localparam int CLK_FREQ = 3_686_400;

    typedef struct packed {
        logic        err;
        logic [7:0]  dat;
        logic [31:0] due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_set;
    logic       uart_rx;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];
    exp_t me;
    logic [7:0] m_last = 8'h00;

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .OSR(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_set   (baud_set),
        .uart_rx    (uart_rx),
        .data_byte  (data_byte),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    // Cycles per oversample tick, straight from the baud table.
    function automatic int div_of(input logic [2:0] bs);
        int baud;
        case (bs)
            3'd1:    baud = 19200;
            3'd2:    baud = 38400;
            3'd3:    baud = 57600;
            3'd4:    baud = 115200;
            default: baud = 9600;
        endcase
        return CLK_FREQ / (baud * 16);
    endfunction

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Drive one 8N1 frame. The model decides the outcome up front: a good stop bit yields the
    // byte, a low stop bit yields an error with the previous byte still shown. The decision
    // lands 9.5625 receiver bit times (153 ticks) plus 3 sync clocks after the start edge.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input real skew,
                              input bit scramble, input int rst_at);
        real        per;
        int         t0;
        logic [9:0] bits;
        logic [2:0] bs_save;
        exp_t       e;
        bs_save = baud_set;
        per     = real'(16 * div_of(baud_set)) / (1.0 + skew);
        bits    = {1'b1, b, 1'b0};
        if (rst_at < 0) begin
            e.err = !stop_ok;
            e.dat = stop_ok ? b : m_last;
            e.due = 32'(cyc + 3 + 153 * div_of(baud_set));
            if (stop_ok) m_last = b;
            q.push_back(e);
        end
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            uart_rx = (k == 9 && !stop_ok) ? 1'b0 : bits[k];
            if (k == 2 && scramble) baud_set = 3'($urandom_range(0, 7));
            if (k == 9) baud_set = bs_save;
            if (k == rst_at) begin
                wait_until(t0 + $rtoi(per * (real'(k) + 0.5) + 0.5));
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                m_last = 8'h00;
                chk("rst_data_byte", data_byte, 8'h00);
                chk("rst_rx_done", rx_done, 0);
                chk("rst_frame_err", frame_err, 0);
                chk("rst_uart_state", uart_state, 0);
            end
            wait_until(t0 + $rtoi(per * real'(k + 1) + 0.5));
        end
        if (!stop_ok) begin
            wait_until(t0 + $rtoi(per * 11.0 + 0.5));
            uart_rx = 1'b1;
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && (rx_done === 1'b1 || frame_err === 1'b1)) begin
            chk("strobe_exclusive", {31'd0, rx_done & frame_err}, 0);
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_strobe: rx_done=%0b frame_err=%0b data=0x%0h, none expected (cycle %0d)",
                         rx_done, frame_err, data_byte, cyc);
            end else begin
                me = q.pop_front();
                chk("strobe_kind_frame_err", frame_err, me.err);
                chk("data_byte", data_byte, me.dat);
                chk("strobe_cycle", cyc, me.due);
            end
        end
    end

    real  skews[2] = '{0.0, 0.025};
    int   nper[5]  = '{1, 2, 4, 6, 12};
    logic [7:0] base;
    int   g0;
    int   deadline;

    initial begin
        reset    = 1'b1;
        uart_rx  = 1'b1;
        baud_set = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_data_byte", data_byte, 8'h00);
        chk("reset_rx_done", rx_done, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_uart_state", uart_state, 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        // 0x55 at 9600
        baud_set = 3'd0;
        send_frame(8'h55, 1'b1, 0.0, 1'b0, -1);
        wait_until(cyc + 2 * 16 * div_of(3'd0));

        // Back-to-back 0x00, 0xFF at 115200 with no idle gap
        baud_set = 3'd4;
        send_frame(8'h00, 1'b1, 0.0, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 0.0, 1'b0, -1);
        wait_until(cyc + 16 * div_of(3'd4));

        // Short low glitch on the idle line at 9600
        baud_set = 3'd0;
        g0 = cyc;
        uart_rx = 1'b0;
        wait_until(g0 + 8);
        uart_rx = 1'b1;
        chk("glitch_state_hi", uart_state, 1);
        wait_until(g0 + 16 * div_of(3'd0));
        chk("glitch_state_lo", uart_state, 0);
        wait_until(cyc + 16 * div_of(3'd0));

        // Bad stop bit then a good frame at 38400
        baud_set = 3'd2;
        send_frame(8'hA3, 1'b0, 0.0, 1'b0, -1);
        wait_until(cyc + 16 * div_of(3'd2));
        send_frame(8'h3C, 1'b1, 0.0, 1'b0, -1);
        wait_until(cyc + 16 * div_of(3'd2));

        // Reset at data bit 4 of an aborted frame, then 0x81
        send_frame(8'hF0, 1'b1, 0.0, 1'b0, 5);
        wait_until(cyc + 2 * 16 * div_of(3'd2));
        send_frame(8'h81, 1'b1, 0.0, 1'b0, -1);
        wait_until(cyc + 16 * div_of(3'd2));

        // Reserved rate code behaves as 9600
        baud_set = 3'd7;
        send_frame(8'($urandom), 1'b1, 0.0, 1'b0, -1);
        wait_until(cyc + 16 * div_of(3'd7));

        // Loopback-style sweep: every rate, incrementing bytes from a random base,
        // nominal and fast transmitter, baud_set disturbed mid-frame.
        for (int s = 0; s < 2; s++) begin
            for (int bs = 0; bs < 5; bs++) begin
                baud_set = 3'(bs);
                base = 8'($urandom);
                for (int i = 0; i < nper[bs]; i++) begin
                    send_frame(base + 8'(i), 1'b1, skews[s], 1'b1, -1);
                    wait_until(cyc + $urandom_range(0, 16));
                end
                wait_until(cyc + 16 * div_of(3'(bs)));
            end
        end

        deadline = cyc + 4000;
        while (q.size() != 0 && cyc < deadline) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
